ps2_kbd_tx: RTL and testbench
=============================

PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 SHALL have parameter CLK_HALF, default 50, system-clock cycles per PS/2 clock half-period (minimum 2).
REQ-002 SHALL have parameter GAP, default 200, idle system-clock cycles enforced between consecutive frames (minimum 1).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, byte-FIFO entries (power of two, minimum 2).
REQ-004 clk  input  1  system clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  8  scan-code byte to transmit.
REQ-007 in_valid  input  1  in_data valid this cycle.
REQ-008 in_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 ps2_clk  output  1  device-driven PS/2 clock, idle high.
REQ-010 ps2_data  output  1  device-driven PS/2 data, idle high.
REQ-011 busy  output  1  frame or inter-frame gap in progress.
REQ-012 count  output  8  frames completed, modulo 256.

Function
REQ-013 Byte SHALL be written into the FIFO on any cycle with in_valid && in_ready; in_ready = FIFO not full.
REQ-014 Frame SHALL be 11 bits: start 0, data bits 0..7 LSB first, odd parity, stop 1.
REQ-015 State machine SHALL use states IDLE, HIGH, LOW, GAP.
REQ-016 IDLE: FIFO non-empty -> pop head, load shift register, drive ps2_data = start bit, go to HIGH; ps2_clk stays 1.
REQ-017 HIGH: ps2_clk = 1 for CLK_HALF cycles, then LOW.
REQ-018 LOW: ps2_clk = 0 for CLK_HALF cycles; then, if bits remain, ps2_clk returns 1, ps2_data advances to next bit in the same cycle, go to HIGH; after stop bit, go to GAP.
REQ-019 ps2_data SHALL change only in the cycle ps2_clk rises, or at frame start; stable throughout every LOW phase.
REQ-020 Frame length SHALL be exactly 22*CLK_HALF cycles from start-bit drive to end of the stop-bit LOW phase.
REQ-021 GAP: ps2_clk = 1, ps2_data = 1 for GAP cycles, count increments by 1 on entry (wraps 255 -> 0), then IDLE.
REQ-022 busy SHALL be 1 in HIGH, LOW, GAP; 0 in IDLE.
REQ-023 Push into a full FIFO SHALL be impossible (in_ready = 0); push and pop in the same cycle SHALL both succeed when not full.
REQ-024 IDLE with empty FIFO SHALL keep both lines high indefinitely.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 On rst: state IDLE, FIFO emptied, ps2_clk = 1, ps2_data = 1, in_ready = 1, busy = 0, count = 0.
REQ-027 rst mid-frame SHALL abort the frame with no count increment; both lines high the cycle after rst is sampled.

Configuration
REQ-028 Macro PS2_TX_PARERR_EN defined: extra input port inject_err (1 bit) is sampled at frame start; if 1, that frame's parity bit is inverted, all else unchanged.
REQ-029 PS2_TX_PARERR_EN undefined: no inject_err port; parity always odd.

Verification
REQ-030 Push 0x1C, CLK_HALF=4 -> bits sampled on ps2_clk falls: 0,0,0,1,1,1,0,0,0,0,1; frame 88 cycles; count 0 -> 1.
REQ-031 Push 0x00 then 0xFF back-to-back -> parity bits 1 and 1; exactly GAP cycles of both lines high between frames; count = 2.
REQ-032 Push 5 bytes on consecutive cycles, FIFO_DEPTH=4, idle start -> in_ready drops once 4 entries held; 5th accepted after first pop; all 5 frames emitted in order.
REQ-033 Assert rst during LOW of data bit 3 -> next cycle ps2_clk = 1, ps2_data = 1, busy = 0, count unchanged, queued bytes discarded.
REQ-034 PS2_TX_PARERR_EN defined, push 0x1C with inject_err = 1 -> parity bit 1; next frame 0x1C with inject_err = 0 -> parity bit 0.

Source files
------------

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: byte FIFO feeding an 11-bit frame serializer with an
// enforced inter-frame gap. Define PS2_TX_PARERR_EN to add the inject_err parity-error port.
module ps2_kbd_tx #(
   parameter int CLK_HALF   = 50,
   parameter int GAP        = 200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
`ifdef PS2_TX_PARERR_EN
   input  logic       inject_err,
`endif
   output logic       in_ready,
   output logic       ps2_clk,
   output logic       ps2_data,
   output logic       busy,
   output logic [7:0] count
);

   localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int TMAX = (CLK_HALF > GAP) ? CLK_HALF : GAP;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_GAP} state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [3:0]      bit_q, bit_d;
   logic [10:0]     frame_q, frame_d;
   logic            clk_q, clk_d, data_q, data_d, busy_q, busy_d;
   logic [7:0]      count_q, count_d;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_q, rd_q;
   logic [AW:0]     fill_q, fill_d;
   logic            ready_q, ready_d;
   logic            push, pop, par;
   logic [7:0]      head;

   assign push = in_valid && ready_q;
   assign head = mem[rd_q];
`ifdef PS2_TX_PARERR_EN
   assign par  = ~(^head) ^ inject_err;
`else
   assign par  = ~(^head);
`endif

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      bit_d   = bit_q;
      frame_d = frame_q;
      clk_d   = clk_q;
      data_d  = data_q;
      count_d = count_q;
      pop     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            clk_d  = 1'b1;
            data_d = 1'b1;
            pop    = (fill_q != '0);
         end
         ST_HIGH: begin
            if (timer_q == TW'(CLK_HALF - 1)) begin
               timer_d = '0;
               clk_d   = 1'b0;
               state_d = ST_LOW;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_LOW: begin
            if (timer_q == TW'(CLK_HALF - 1)) begin
               timer_d = '0;
               clk_d   = 1'b1;
               if (bit_q == 4'd10) begin
                  data_d  = 1'b1;
                  count_d = count_q + 8'd1;
                  state_d = ST_GAP;
               end else begin
                  // Data moves with the rising clock so it is stable across every low phase.
                  frame_d = frame_q >> 1;
                  data_d  = frame_q[1];
                  bit_d   = bit_q + 4'd1;
                  state_d = ST_HIGH;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_GAP: begin
            if (timer_q == TW'(GAP - 1)) begin
               timer_d = '0;
               state_d = ST_IDLE;
               // Chain straight into the next frame so the idle time is exactly GAP cycles.
               pop     = (fill_q != '0);
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
      endcase
      if (pop) begin
         frame_d = {1'b1, par, head, 1'b0};
         data_d  = 1'b0;
         clk_d   = 1'b1;
         bit_d   = '0;
         timer_d = '0;
         state_d = ST_HIGH;
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_comb begin
      fill_d = fill_q;
      if (push && !pop)      fill_d = fill_q + (AW+1)'(1);
      else if (pop && !push) fill_d = fill_q - (AW+1)'(1);
      ready_d = (fill_d != (AW+1)'(FIFO_DEPTH));
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         bit_q   <= '0;
         frame_q <= '1;
         clk_q   <= 1'b1;
         data_q  <= 1'b1;
         busy_q  <= 1'b0;
         count_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         fill_q  <= '0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         bit_q   <= bit_d;
         frame_q <= frame_d;
         clk_q   <= clk_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         fill_q  <= fill_d;
         ready_q <= ready_d;
         if (push) wr_q <= wr_q + AW'(1);
         if (pop)  rd_q <= rd_q + AW'(1);
      end
   end

   // NOTE: storage is not reset; the pointers and fill level alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= in_data;
   end

   assign in_ready = ready_q;
   assign ps2_clk  = clk_q;
   assign ps2_data = data_q;
   assign busy     = busy_q;
   assign count    = count_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a line monitor decodes frames from the PS/2 wires and
// the directed/random sequence compares them with frames built from the byte queue.
module tb_ps2_kbd_tx;

   localparam int CH = 4;
   localparam int GP = 10;
   localparam int FD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready, ps2_clk, ps2_data, busy;
   logic [7:0] count;
`ifdef PS2_TX_PARERR_EN
   logic       inj_err = 1'b0;
`endif

   ps2_kbd_tx #(.CLK_HALF(CH), .GAP(GP), .FIFO_DEPTH(FD)) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
`ifdef PS2_TX_PARERR_EN
      .inject_err(inj_err),
`endif
      .in_ready(in_ready),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .busy(busy),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] bits;
      int          len;
      int          gap;
      logic [7:0]  cnt;
      logic        stable;
   } rec_t;

   rec_t recs[$];
   rec_t cur;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   nfall = 0;
   int   start_cyc = 0;
   int   last_end = -1;
   bit   in_frame = 1'b0;
   logic prev_clk = 1'b1;
   logic prev_data = 1'b1;

   // Line monitor: samples the wires mid-cycle and records one entry per completed frame.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         in_frame  = 1'b0;
         nfall     = 0;
         last_end  = -1;
         prev_clk  = 1'b1;
         prev_data = 1'b1;
      end else begin
         if (!in_frame) begin
            if (ps2_clk && !ps2_data && prev_data) begin
               in_frame   = 1'b1;
               start_cyc  = cyc;
               nfall      = 0;
               cur.bits   = '0;
               cur.stable = 1'b1;
               cur.gap    = (last_end < 0) ? -1 : cyc - last_end;
            end
         end else begin
            if (ps2_data !== prev_data && !(ps2_clk && !prev_clk)) cur.stable = 1'b0;
            if (prev_clk && !ps2_clk) begin
               if (nfall < 11) cur.bits[nfall] = ps2_data;
               nfall++;
            end
            if (!prev_clk && ps2_clk && nfall == 11) begin
               cur.len  = cyc - start_cyc;
               cur.cnt  = count;
               recs.push_back(cur);
               last_end = cyc;
               in_frame = 1'b0;
            end
         end
         prev_clk  = ps2_clk;
         prev_data = ps2_data;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame: start 0, data LSB first, odd parity (optionally inverted), stop 1.
   function automatic logic [10:0] exp_frame(input logic [7:0] d, input logic inj);
      int ones = 0;
      logic p;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      p = ((ones % 2) == 0) ? 1'b1 : 1'b0;
      return {1'b1, p ^ inj, d, 1'b0};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      recs.delete();
   endtask

   task automatic push(input logic [7:0] d);
      int t = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && t < 2000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("push_accept", t < 2000, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_recs(input int n, input int budget);
      int t = 0;
      while (recs.size() < n && t < budget) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("frame_wait", recs.size() >= n, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic inj, input logic [7:0] cnt,
                               input int gap_min, input int gap_max);
      rec_t r;
      check("frame_present", recs.size() > 0, 1);
      if (recs.size() == 0) return;
      r = recs.pop_front();
      check("frame_bits", r.bits, exp_frame(d, inj));
      check("frame_len", r.len, 22 * CH);
      check("data_stable", r.stable, 1);
      check("count", r.cnt, cnt);
      if (gap_min >= 0) check("gap_min", r.gap >= gap_min, 1);
      if (gap_max >= 0) check("gap_max", r.gap <= gap_max, 1);
   endtask

   logic [7:0] bq[$];
   logic [7:0] d;

   initial begin
      // Reset state and idle behaviour.
      do_reset();
      check("rst_ps2_clk", ps2_clk, 1);
      check("rst_ps2_data", ps2_data, 1);
      check("rst_in_ready", in_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_count", count, 0);
      idle(30);
      check("idle_clk", ps2_clk, 1);
      check("idle_data", ps2_data, 1);
      check("idle_busy", busy, 0);

      // Single 0x1C frame.
      push(8'h1C);
      wait_recs(1, 400);
      if (recs.size() > 0) check("kc1c_literal", recs[0].bits, 11'b10000111000);
      check("gap_busy", busy, 1);
      expect_frame(8'h1C, 1'b0, 8'd1, -1, -1);
      idle(GP + 5);
      check("post_gap_busy", busy, 0);
      check("post_gap_count", count, 1);

      // Back-to-back 0x00 / 0xFF: both parity bits 1, gap exactly GP.
      do_reset();
      push(8'h00);
      push(8'hFF);
      wait_recs(2, 600);
      expect_frame(8'h00, 1'b0, 8'd1, -1, -1);
      expect_frame(8'hFF, 1'b0, 8'd2, GP, GP);
      idle(GP + 5);
      check("b2b_count", count, 2);

      // Five consecutive pushes from idle, emitted in order.
      do_reset();
      for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
      wait_recs(5, 1500);
      for (int i = 0; i < 5; i++)
         expect_frame(8'h10 + 8'(i), 1'b0, 8'(i + 1), (i == 0) ? -1 : GP, (i == 0) ? -1 : GP);

      // FIFO full while a frame is on the wire; the extra byte waits for a pop.
      do_reset();
      push(8'hA0);
      idle(3);
      for (int i = 1; i <= FD; i++) push(8'hA0 + 8'(i));
      check("full_in_ready", in_ready, 0);
      push(8'hA5);
      check("full_hold_frames", recs.size(), 1);
      wait_recs(6, 2000);
      for (int i = 0; i < 6; i++)
         expect_frame(8'hA0 + 8'(i), 1'b0, 8'(i + 1), (i == 0) ? -1 : GP, (i == 0) ? -1 : GP);

      // Reset during the low phase of data bit 3 aborts the frame and empties the FIFO.
      do_reset();
      push(8'h5A);
      push(8'h33);
      push(8'h77);
      begin
         int t = 0;
         while (!(in_frame && nfall == 5) && t < 400) begin
            @(posedge clk);
            #1;
            t++;
         end
         check("reach_bit3_low", t < 400, 1);
      end
      check("bit3_low_clk", ps2_clk, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_clk", ps2_clk, 1);
      check("abort_data", ps2_data, 1);
      check("abort_busy", busy, 0);
      check("abort_count", count, 0);
      check("abort_ready", in_ready, 1);
      idle(400);
      check("abort_no_frames", recs.size(), 0);
      check("abort_idle_busy", busy, 0);
      check("abort_idle_count", count, 0);

      // Random bytes with random spacing.
      do_reset();
      bq.delete();
      for (int i = 0; i < 16; i++) begin
         d = 8'($urandom);
         bq.push_back(d);
         push(d);
         idle($urandom_range(0, 120));
      end
      wait_recs(16, 4000);
      for (int i = 0; i < 16; i++)
         expect_frame(bq[i], 1'b0, 8'(i + 1), (i == 0) ? -1 : GP, -1);

`ifdef PS2_TX_PARERR_EN
      // Parity-error injection applies only to the frame started while it is set.
      do_reset();
      inj_err = 1'b1;
      push(8'h1C);
      idle(2);
      inj_err = 1'b0;
      push(8'h1C);
      wait_recs(2, 600);
      if (recs.size() > 1) begin
         check("inj_parity_on", recs[0].bits[9], 1);
         check("inj_parity_off", recs[1].bits[9], 0);
      end
      expect_frame(8'h1C, 1'b1, 8'd1, -1, -1);
      expect_frame(8'h1C, 1'b0, 8'd2, GP, GP);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
